// File: rtl/input_arbiter.sv
// Player-input front end: debounces the board buttons and hands input ownership
// between the AI, the board buttons and the SNES gamepad.
module input_arbiter #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned IDLE_TICKS     = 2048,
  parameter int unsigned SELECT_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       countdown_en,
  input  logic       btn_up_raw,
  input  logic       btn_down_raw,
  input  logic       gp_present,
  input  logic       gp_up,
  input  logic       gp_down,
  input  logic       gp_a,
  input  logic       gp_b,
  input  logic       gp_start,
  input  logic       gp_select,
  input  logic       ai_up,
  input  logic       game_frozen,
  output logic       button_up,
  output logic       button_down,
  output logic       button_start,
  output logic [1:0] mode,
  output logic       mode_change
);

  localparam logic [1:0] ST_AI      = 2'd0;
  localparam logic [1:0] ST_BUTTON  = 2'd1;
  localparam logic [1:0] ST_GAMEPAD = 2'd2;

  localparam logic [3:0]  DB_LIM   = 4'(DEBOUNCE_TICKS);
  localparam logic [11:0] IDLE_LIM = 12'(IDLE_TICKS);
  localparam logic [5:0]  SEL_LIM  = 6'(SELECT_HOLD);

  logic [1:0]  sync1_q, sync2_q;
  logic        db_up_q, db_up_d, db_down_q, db_down_d;
  logic [3:0]  db_up_cnt_q, db_up_cnt_d, db_down_cnt_q, db_down_cnt_d;
  logic [1:0]  state_q, state_d;
  logic [11:0] idle_q, idle_d;
  logic [5:0]  sel_q, sel_d;
  logic        armed_q, armed_d;
  logic        gp_present_q;
  logic        up_q, up_d, down_q, down_d, start_q, start_d;
  logic        mode_change_q, mode_change_d;

  logic gp_act, btn_act, human_act, gp_fall, to_ai, changing, owner_quiet;

  // Returns {debounced, count}: counter only advances while the synchronized
  // input disagrees with the debounced value.
  function automatic logic [4:0] db_step(input logic s, input logic d,
                                         input logic [3:0] c, input logic en);
    logic [3:0] nxt;
    nxt = c + 4'd1;
    db_step = {d, c};
    if (s == d) begin
      db_step = {d, 4'd0};
    end else if (en) begin
      if (nxt == DB_LIM) db_step = {~d, 4'd0};
      else               db_step = {d, nxt};
    end
  endfunction

  always_comb begin
    {db_up_d, db_up_cnt_d}     = db_step(sync2_q[0], db_up_q, db_up_cnt_q, countdown_en);
    {db_down_d, db_down_cnt_d} = db_step(sync2_q[1], db_down_q, db_down_cnt_q, countdown_en);
  end

  always_comb begin
    gp_act    = gp_present & (gp_up | gp_down | gp_a | gp_b | gp_start);
    btn_act   = db_up_q | db_down_q;
    human_act = gp_act | btn_act;
    gp_fall   = gp_present_q & ~gp_present;
    to_ai     = ((idle_q == IDLE_LIM) || (sel_q == SEL_LIM)) && !human_act;

    state_d = state_q;
    case (state_q)
      ST_AI: begin
        if (gp_act)       state_d = ST_GAMEPAD;
        else if (btn_act) state_d = ST_BUTTON;
      end
      ST_BUTTON: begin
        if (to_ai)       state_d = ST_AI;
        else if (gp_act) state_d = ST_GAMEPAD;
      end
      ST_GAMEPAD: begin
        if (gp_fall)                  state_d = ST_BUTTON;
        else if (to_ai)               state_d = ST_AI;
        else if (btn_act && !gp_act)  state_d = ST_BUTTON;
      end
      default: state_d = ST_AI;
    endcase
    changing = (state_d != state_q);

    idle_d = idle_q;
    if (human_act || !game_frozen || state_q == ST_AI) idle_d = '0;
    else if (countdown_en && idle_q != IDLE_LIM)       idle_d = idle_q + 12'd1;

    sel_d = '0;
    if (gp_present && gp_select && game_frozen) begin
      if (sel_q == SEL_LIM)  sel_d = '0;
      else if (countdown_en) sel_d = sel_q + 6'd1;
      else                   sel_d = sel_q;
    end

    case (state_q)
      ST_BUTTON:  owner_quiet = !db_up_q && !db_down_q;
      ST_GAMEPAD: owner_quiet = !(gp_up | gp_down | gp_a | gp_b | gp_start);
      default:    owner_quiet = !ai_up;
    endcase

    // The press that claims ownership is swallowed until the new owner goes quiet.
    armed_d = armed_q;
    if (changing && state_d != ST_AI) armed_d = 1'b0;
    else if (!armed_q && owner_quiet) armed_d = 1'b1;

    up_d    = 1'b0;
    down_d  = 1'b0;
    start_d = 1'b0;
    if (!changing && armed_q) begin
      case (state_q)
        ST_AI: begin
          up_d    = ai_up;
          start_d = ai_up;
        end
        ST_BUTTON: begin
          up_d    = db_up_q;
          down_d  = db_down_q;
          start_d = db_up_q;
        end
        ST_GAMEPAD: begin
          up_d    = gp_up | gp_a;
          down_d  = gp_down | gp_b;
          start_d = gp_start | gp_a;
        end
        default: ;
      endcase
    end
    mode_change_d = changing;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      db_up_q       <= 1'b0;
      db_down_q     <= 1'b0;
      db_up_cnt_q   <= '0;
      db_down_cnt_q <= '0;
      state_q       <= ST_AI;
      idle_q        <= '0;
      sel_q         <= '0;
      armed_q       <= 1'b1;
      gp_present_q  <= 1'b0;
      up_q          <= 1'b0;
      down_q        <= 1'b0;
      start_q       <= 1'b0;
      mode_change_q <= 1'b0;
    end else begin
      sync1_q       <= {btn_down_raw, btn_up_raw};
      sync2_q       <= sync1_q;
      db_up_q       <= db_up_d;
      db_down_q     <= db_down_d;
      db_up_cnt_q   <= db_up_cnt_d;
      db_down_cnt_q <= db_down_cnt_d;
      state_q       <= state_d;
      idle_q        <= idle_d;
      sel_q         <= sel_d;
      armed_q       <= armed_d;
      gp_present_q  <= gp_present;
      up_q          <= up_d;
      down_q        <= down_d;
      start_q       <= start_d;
      mode_change_q <= mode_change_d;
    end
  end

  assign button_up    = up_q;
  assign button_down  = down_q;
  assign button_start = start_q;
  assign mode         = state_q;
  assign mode_change  = mode_change_q;

endmodule

// File: tb/tb_input_arbiter.sv
// Directed bench for input_arbiter: vector table for output mapping plus
// hand-written ownership, debounce, idle and select sequences.
module tb_input_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       countdown_en = 1'b0;
  logic       btn_up_raw = 1'b0, btn_down_raw = 1'b0;
  logic       gp_present = 1'b0;
  logic       gp_up = 1'b0, gp_down = 1'b0, gp_a = 1'b0, gp_b = 1'b0;
  logic       gp_start = 1'b0, gp_select = 1'b0;
  logic       ai_up = 1'b0;
  logic       game_frozen = 1'b0;
  logic       button_up, button_down, button_start;
  logic [1:0] mode;
  logic       mode_change;

  int errors = 0;
  int checks = 0;
  int mc_count = 0;
  int mc_base;

  input_arbiter #(
    .DEBOUNCE_TICKS(4),
    .IDLE_TICKS(8),
    .SELECT_HOLD(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .countdown_en(countdown_en),
    .btn_up_raw(btn_up_raw), .btn_down_raw(btn_down_raw),
    .gp_present(gp_present), .gp_up(gp_up), .gp_down(gp_down),
    .gp_a(gp_a), .gp_b(gp_b), .gp_start(gp_start), .gp_select(gp_select),
    .ai_up(ai_up), .game_frozen(game_frozen),
    .button_up(button_up), .button_down(button_down), .button_start(button_start),
    .mode(mode), .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mode_change) mc_count++;

  typedef struct {
    logic       ai;
    logic       pres;
    logic [4:0] gp;   // {up, down, a, b, start}
    logic [2:0] exp;  // {button_up, button_down, button_start}
    logic [1:0] md;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      countdown_en = 1'b1;
      step();
      countdown_en = 1'b0;
      step();
      step();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'b10000, 3'b101, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 5'b11111, 3'b000, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 5'b00010, 3'b101, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 5'b00000, 3'b000, 2'd0};
    vecs[4]  = '{1'b0, 1'b1, 5'b10000, 3'b100, 2'd2};
    vecs[5]  = '{1'b0, 1'b1, 5'b00100, 3'b101, 2'd2};
    vecs[6]  = '{1'b0, 1'b1, 5'b01000, 3'b010, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 5'b00010, 3'b010, 2'd2};
    vecs[8]  = '{1'b0, 1'b1, 5'b00001, 3'b001, 2'd2};
    vecs[9]  = '{1'b1, 1'b1, 5'b00110, 3'b111, 2'd2};
    vecs[10] = '{1'b1, 1'b1, 5'b00000, 3'b000, 2'd2};

    // Reset values
    step();
    step();
    check("reset_outs", {29'd0, button_up, button_down, button_start}, 0);
    check("reset_mode", mode, 0);
    check("reset_mc", mode_change, 0);
    rst_n = 1'b1;
    step();

    // AI pulse of 3 cycles
    ai_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ai_pulse_up", button_up, 1);
      check("ai_pulse_start", button_start, 1);
    end
    ai_up = 1'b0;
    step();
    check("ai_pulse_end", button_up, 0);
    check("ai_pulse_mode", mode, 0);

    // AI-owner mapping; gamepad ignored while not present
    for (int i = 0; i < 4; i++) begin
      ai_up = vecs[i].ai;
      gp_present = vecs[i].pres;
      {gp_up, gp_down, gp_a, gp_b, gp_start} = vecs[i].gp;
      step();
      check($sformatf("vec%0d_outs", i), {button_up, button_down, button_start}, vecs[i].exp);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].md);
    end

    // Gamepad handover: claiming press is swallowed
    ai_up = 1'b0;
    gp_present = 1'b1;
    {gp_up, gp_down, gp_a, gp_b, gp_start} = 5'b00100;
    step();
    check("gp_handover_mode", mode, 2);
    check("gp_handover_mc", mode_change, 1);
    check("gp_handover_up", button_up, 0);
    step();
    check("gp_swallow_mc", mode_change, 0);
    check("gp_swallow_up", button_up, 0);
    {gp_up, gp_down, gp_a, gp_b, gp_start} = 5'b00000;
    step();
    step();
    check("gp_armed_idle", button_up, 0);

    for (int i = 4; i < 11; i++) begin
      ai_up = vecs[i].ai;
      gp_present = vecs[i].pres;
      {gp_up, gp_down, gp_a, gp_b, gp_start} = vecs[i].gp;
      step();
      check($sformatf("vec%0d_outs", i), {button_up, button_down, button_start}, vecs[i].exp);
      check($sformatf("vec%0d_mode", i), mode, vecs[i].md);
      check($sformatf("vec%0d_mc", i), mode_change, 0);
    end

    // Gamepad unplugged while owning -> BUTTON
    ai_up = 1'b0;
    gp_present = 1'b0;
    gp_up = 1'b1;
    step();
    check("unplug_mode", mode, 1);
    check("unplug_mc", mode_change, 1);
    check("unplug_up", button_up, 0);
    gp_up = 1'b0;
    step();
    check("unplug_mode_hold", mode, 1);
    check("unplug_mc_clear", mode_change, 0);

    // Idle return, restarted by a press that debounces at strobe 7
    game_frozen = 1'b1;
    strobe(3);
    btn_up_raw = 1'b1;
    idle(3);
    strobe(4);
    strobe(1);
    check("idle_restart_mode", mode, 1);
    check("idle_btn_up", button_up, 1);
    btn_up_raw = 1'b0;
    idle(3);
    strobe(4);
    strobe(7);
    check("idle_7_mode", mode, 1);
    check("idle_7_up", button_up, 0);
    strobe(1);
    check("idle_8_mode", mode, 0);

    // Bouncing raw button claims ownership once, press swallowed
    game_frozen = 1'b0;
    mc_base = mc_count;
    for (int i = 0; i < 2; i++) begin
      btn_up_raw = 1'b1;
      idle(3);
      strobe(2);
      btn_up_raw = 1'b0;
      idle(3);
      strobe(2);
    end
    check("bounce_no_change", mode, 0);
    btn_up_raw = 1'b1;
    idle(3);
    strobe(4);
    check("bounce_mode", mode, 1);
    check("bounce_mc_count", mc_count - mc_base, 1);
    check("bounce_swallow", button_up, 0);
    strobe(2);
    check("bounce_swallow_hold", button_up, 0);
    btn_up_raw = 1'b0;
    idle(3);
    strobe(4);
    idle(2);
    check("release_up", button_up, 0);
    btn_up_raw = 1'b1;
    idle(3);
    strobe(3);
    check("press_3_strobes", button_up, 0);
    strobe(1);
    check("press_4_up", button_up, 1);
    check("press_4_start", button_start, 1);
    check("press_mc_count", mc_count - mc_base, 1);
    btn_up_raw = 1'b0;
    idle(3);
    strobe(4);
    idle(2);
    check("press_release", button_up, 0);

    // SELECT hold: ignored while a game runs, forces AI when frozen
    gp_present = 1'b1;
    gp_select = 1'b1;
    strobe(8);
    check("select_running_mode", mode, 1);
    game_frozen = 1'b1;
    strobe(5);
    check("select_5_mode", mode, 1);
    strobe(1);
    check("select_6_mode", mode, 0);
    gp_select = 1'b0;
    game_frozen = 1'b0;
    idle(2);

    // Gamepad and debounced button first activity in the same cycle
    mc_base = mc_count;
    btn_up_raw = 1'b1;
    idle(3);
    strobe(3);
    countdown_en = 1'b1;
    step();
    countdown_en = 1'b0;
    gp_up = 1'b1;
    step();
    check("simul_mode", mode, 2);
    check("simul_mc", mode_change, 1);
    step();
    check("simul_mode_hold", mode, 2);
    check("simul_mc_clear", mode_change, 0);
    check("simul_swallow", button_up, 0);
    step();
    check("simul_mc_count", mc_count - mc_base, 1);

    // Reset mid-operation
    btn_up_raw = 1'b0;
    rst_n = 1'b0;
    step();
    check("midreset_mode", mode, 0);
    check("midreset_mc", mode_change, 0);
    check("midreset_up", button_up, 0);
    rst_n = 1'b1;
    gp_up = 1'b0;
    gp_present = 1'b0;
    ai_up = 1'b1;
    step();
    step();
    check("post_reset_ai", button_up, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_arbiter.md
# input_arbiter

Player-input front end for the dino game, sitting directly upstream of `player_controller`. It takes two raw board buttons, the decoded SNES gamepad Pmod buttons and the AI controller's jump request, and produces the single `button_up` / `button_down` / `button_start` set that `player_controller` consumes. It debounces the raw buttons on the vertical-position tick and runs an input-ownership state machine: attract-mode AI by default, handover to a human on the first press, and return to AI after idling or on a gamepad SELECT hold.

## Interface
Parameters:
- `DEBOUNCE_TICKS`, 4, consecutive stable `countdown_en` samples before a debounced raw button changes; range 1..15.
- `IDLE_TICKS`, 2048, `countdown_en` pulses with `game_frozen`=1 and no human input before ownership returns to AI; range 1..4095.
- `SELECT_HOLD`, 16, `countdown_en` pulses gamepad SELECT must be held while `game_frozen`=1 to force AI; range 1..63.

Ports (one clock `clk`; reset `rst_n` is synchronous, active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `countdown_en`  in  1  single-cycle pulse on each rising edge of vpos bit 5; debounce/timer sample strobe.
- `btn_up_raw`  in  1  asynchronous board button (ui_in[0]), active high.
- `btn_down_raw`  in  1  asynchronous board button (ui_in[1]), active high.
- `gp_present`  in  1  gamepad connected (already synchronous).
- `gp_up`, `gp_down`, `gp_a`, `gp_b`, `gp_start`, `gp_select`  in  1 each  gamepad buttons (already synchronous).
- `ai_up`  in  1  AI controller jump request.
- `game_frozen`  in  1  from `player_controller`; 1 when no game is running.
- `button_up`  out  1  jump / start request to `player_controller`.
- `button_down`  out  1  duck request.
- `button_start`  out  1  start request.
- `mode`  out  2  current owner: 2'd0 AI, 2'd1 BUTTON, 2'd2 GAMEPAD (2'd3 unused).
- `mode_change`  out  1  one-cycle pulse on every ownership change.

## Operation
- Raw buttons: 2-flop synchronizer each, then debouncer: 4-bit counter per button, cleared whenever the synchronized value equals the debounced value, incremented on `countdown_en` otherwise; debounced value toggles and counter clears when the count reaches `DEBOUNCE_TICKS`.
- Gamepad human activity: `gp_present` & (`gp_up`|`gp_down`|`gp_a`|`gp_b`|`gp_start`). Button activity: debounced up | debounced down.
- FSM states AI, BUTTON, GAMEPAD; reset state AI.
  - AI -> GAMEPAD on gamepad activity; AI -> BUTTON on button activity; both same cycle -> GAMEPAD.
  - BUTTON -> GAMEPAD on gamepad activity. GAMEPAD -> BUTTON on button activity while no gamepad activity.
  - GAMEPAD -> BUTTON when `gp_present` falls (takes priority over all other GAMEPAD transitions).
  - BUTTON/GAMEPAD -> AI when idle counter reaches `IDLE_TICKS`, or select counter reaches `SELECT_HOLD`. Idle-to-AI beats any same-cycle human transition only if no human activity that cycle.
- Idle counter (12 bit): cleared on any human activity, when `game_frozen`=0, or in AI; incremented on `countdown_en` otherwise; saturates.
- Select counter (6 bit): counts `countdown_en` while `gp_present`&`gp_select`&`game_frozen`; cleared otherwise or on reaching `SELECT_HOLD`.
- Swallow: on every transition into BUTTON or GAMEPAD, an `armed` flag clears; outputs stay 0 until all inputs of the new owner read 0 for one cycle, then `armed`=1. Handover press never reaches `player_controller`.
- Output mapping (when armed): AI: up=`ai_up`, down=0, start=`ai_up`. BUTTON: up=db_up, down=db_down, start=db_up. GAMEPAD: up=`gp_up`|`gp_a`, down=`gp_down`|`gp_b`, start=`gp_start`|`gp_a`.

## Timing
- All outputs registered; reset values: `button_*`=0, `mode`=2'd0, `mode_change`=0; all counters, synchronizers, debounced values 0, `armed`=1.
- AI and gamepad paths: output follows input 1 cycle later.
- Raw path: 2 sync cycles + `DEBOUNCE_TICKS` strobes of stability + 1 output cycle.
- FSM transition registers on the cycle after its condition; `mode` and `mode_change` update together; outputs forced 0 that same cycle.
- Reset asserted mid-operation returns everything to reset values on the next edge, regardless of counters.

## Test plan
- Reset, `ai_up` pulse 3 cycles -> `button_up`/`button_start` high 3 cycles starting 1 cycle later; `mode`=0.
- `btn_up_raw` bouncing 0/1 every 2 strobes then held 1 for 4 strobes (`DEBOUNCE_TICKS`=4) -> one `mode_change`, `mode`=1, `button_up` stays 0 until release, next clean press drives `button_up`=1.
- Gamepad and raw button first press in same cycle from AI -> `mode`=2, single `mode_change`.
- In GAMEPAD, drop `gp_present` -> `mode`=1 next cycle, outputs 0.
- `game_frozen`=1, no input, `IDLE_TICKS`=8 -> `mode`=0 after 8th strobe; human press at strobe 7 restarts count.
- Hold `gp_select` 16 strobes with `game_frozen`=1 -> `mode`=0; same hold with `game_frozen`=0 -> no change.
